mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl_pkg.sv | 36 +++
 rtl/mem_req_watchdog.sv | 39 +++
 rtl/mem_req_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// rtl/mem_req_ctrl_pkg.sv - shared data-bus types, controller state enum and defaults
// Purpose: common definitions for mem_req_ctrl and mem_req_watchdog.
// Contents: word_t/addr_t, dbus_req_t (valid/addr/size/strobe/data),
//           dbus_resp_t (addr_ok/data_ok/data), mem_ctrl_state_t, DEFAULT_TIMEOUT_CYCLES.
package mem_req_ctrl_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;
    typedef logic [1:0]  msize_t;
    typedef logic [3:0]  strobe_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } mem_ctrl_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_req_watchdog.sv
// rtl/mem_req_watchdog.sv - bus-progress watchdog for mem_req_ctrl
// Purpose: counts consecutive cycles spent in one waiting state and fires
//          on the TIMEOUT_CYCLES-th such cycle. Built only with MEM_REQ_TIMEOUT_EN.
// Ports: clk, resetn (async active-low), busy (controller in ADDR/DATA/DRAIN),
//        stay (controller remains in the same state next cycle), fire (timeout pulse).
`ifdef MEM_REQ_TIMEOUT_EN
module mem_req_watchdog
    import mem_req_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic busy,
    input  logic stay,
    output logic fire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of cycles already spent in the current waiting
    // state, so it reads 0 on the first cycle after entering one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (busy && stay) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Firing forces the controller to IDLE, which clears cnt, so it never wraps.
    assign fire = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - M-stage data-bus request controller
// Purpose: issues the M-stage memory op on the data bus, holds the pipeline
//          until the response arrives, and presents the captured word.
// Ports: clk, resetn (async active-low), in_valid/in_req (M-stage op),
//        advance (M->W), abort (flush), dreq/dresp (data bus), stall,
//        rvalid/rdata (captured word), timeout (only with MEM_REQ_TIMEOUT_EN).
// Option: MEM_REQ_TIMEOUT_EN adds the mem_req_watchdog and the timeout port.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  dbus_req_t  in_req,
    input  logic       advance,
    input  logic       abort,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       stall,
    output logic       rvalid,
    output word_t      rdata
`ifdef MEM_REQ_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    mem_ctrl_state_t state, state_next;
    dbus_req_t       req_q;
    word_t           rdata_q;
    logic            abort_q, abort_q_next;
    logic            latch, capture, kill;
    logic            wd_fire;

`ifdef MEM_REQ_TIMEOUT_EN
    logic wd_busy, wd_stay;

    assign wd_busy = (state == ADDR) || (state == DATA) || (state == DRAIN);
    assign wd_stay = (state_next == state);

    mem_req_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .busy   (wd_busy),
        .stay   (wd_stay),
        .fire   (wd_fire)
    );

    assign timeout = wd_fire;
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        abort_q_next = abort_q;
        dreq         = req_q;
        dreq.valid   = 1'b0;
        stall        = 1'b0;
        rvalid       = 1'b0;
        latch        = 1'b0;
        capture      = 1'b0;
        kill         = abort || abort_q;

        case (state)
            IDLE: begin
                // Issue combinationally so a zero-wait bus completes in the issue cycle.
                dreq       = in_req;
                dreq.valid = 1'b0;
                if (in_valid && !abort) begin
                    dreq.valid = 1'b1;
                    stall      = 1'b1;
                    latch      = 1'b1;
                    if (dresp.addr_ok && dresp.data_ok) begin
                        state_next = DONE;
                        capture    = 1'b1;
                    end else if (dresp.addr_ok) begin
                        state_next = DATA;
                    end else begin
                        state_next = ADDR;
                    end
                end
            end
            ADDR: begin
                // A request once offered stays offered until accepted, even if
                // aborted; the abort is remembered and applied at acceptance.
                dreq.valid   = 1'b1;
                stall        = 1'b1;
                abort_q_next = kill;
                if (dresp.addr_ok) begin
                    abort_q_next = 1'b0;
                    if (kill) begin
                        state_next = dresp.data_ok ? IDLE : DRAIN;
                    end else if (dresp.data_ok) begin
                        state_next = DONE;
                        capture    = 1'b1;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                stall = 1'b1;
                if (abort) begin
                    state_next = dresp.data_ok ? IDLE : DRAIN;
                end else if (dresp.data_ok) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (dresp.data_ok) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                rvalid = 1'b1;
                if (advance || abort) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (wd_fire) begin
            state_next   = IDLE;
            abort_q_next = 1'b0;
            capture      = 1'b0;
        end

        // IDLE issues straight from in_req, so gate with reset to keep the
        // bus and pipeline quiet while resetn is low.
        if (!resetn) begin
            dreq.valid = 1'b0;
            stall      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_next;
            abort_q <= abort_q_next;
            if (latch) begin
                req_q <= in_req;
            end
            if (capture) begin
                rdata_q <= dresp.data;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench for mem_req_ctrl
module tb_mem_req_ctrl;
    import mem_req_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    dbus_req_t  in_req;
    logic       advance;
    logic       abort;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       stall;
    logic       rvalid;
    word_t      rdata;
`ifdef MEM_REQ_TIMEOUT_EN
    logic       timeout;
`endif

    int    total = 0;
    int    bad   = 0;
    word_t exp_q[$];

    always #5 clk = ~clk;

    mem_req_ctrl #(
`ifdef MEM_REQ_TIMEOUT_EN
        .TIMEOUT_CYCLES(8)
`else
        .TIMEOUT_CYCLES(255)
`endif
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_req   (in_req),
        .advance  (advance),
        .abort    (abort),
        .dreq     (dreq),
        .dresp    (dresp),
        .stall    (stall),
        .rvalid   (rvalid),
        .rdata    (rdata)
`ifdef MEM_REQ_TIMEOUT_EN
        ,
        .timeout  (timeout)
`endif
    );

    function automatic dbus_req_t mk(input addr_t a, input strobe_t s, input word_t d);
        dbus_req_t r;
        r.valid  = 1'b0;
        r.addr   = a;
        r.size   = 2'd2;
        r.strobe = s;
        r.data   = d;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        in_valid = 1'b0;
        advance  = 1'b0;
        abort    = 1'b0;
        in_req   = '0;
        dresp    = '0;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        quiet();
        in_valid = 1'b1;
        in_req   = mk(32'h40, 4'hF, 32'h0);
        @(negedge clk);
        total++; if (dreq.valid !== 1'b0) begin bad++; $display("FAIL reset_dreq_valid: got %b want 0", dreq.valid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        step();
        quiet();
        resetn = 1'b1;
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_idle_stall: got %b want 0", stall); end
    endtask

    task automatic test_fast_load();
        word_t e;
        step();
        in_valid = 1'b1;
        in_req   = mk(32'h100, 4'h0, 32'h0);
        dresp    = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h12345678};
        exp_q.push_back(32'h12345678);
        @(negedge clk);
        total++; if (dreq.valid !== 1'b1) begin bad++; $display("FAIL fast_issue_valid: got %b want 1", dreq.valid); end
        total++; if (dreq.addr !== 32'h100) begin bad++; $display("FAIL fast_issue_addr: got %h want 00000100", dreq.addr); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fast_issue_stall: got %b want 1", stall); end
        step();
        quiet();
        @(negedge clk);
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL fast_rvalid: got %b want 1", rvalid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fast_done_stall: got %b want 0", stall); end
        if (rvalid) begin
            e = exp_q.pop_front();
            total++; if (rdata !== e) begin bad++; $display("FAIL fast_rdata: got %h want %h", rdata, e); end
        end
        step();
        @(negedge clk);
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL fast_hold_rvalid: got %b want 1", rvalid); end
        total++; if (rdata !== 32'h12345678) begin bad++; $display("FAIL fast_hold_rdata: got %h want 12345678", rdata); end
        step();
        advance = 1'b1;
        step();
        advance = 1'b0;
        @(negedge clk);
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL fast_after_adv_rvalid: got %b want 0", rvalid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fast_after_adv_stall: got %b want 0", stall); end
    endtask

    task automatic test_slow_load();
        int    nvalid = 0;
        int    nstall = 0;
        word_t e;
        for (int i = 0; i < 8; i++) begin
            step();
            in_valid      = (i < 6);
            in_req        = (i == 0) ? mk(32'h200, 4'h0, 32'h0) : mk(32'hDEAD0000, 4'h3, 32'h1);
            dresp.addr_ok = (i == 3);
            dresp.data_ok = (i == 5);
            dresp.data    = (i == 5) ? 32'hA5A50001 : 32'h0;
            advance       = (i == 6);
            if (i == 0) exp_q.push_back(32'hA5A50001);
            @(negedge clk);
            if (dreq.valid === 1'b1) begin
                nvalid++;
                total++; if (dreq.addr !== 32'h200) begin bad++; $display("FAIL slow_addr_stable c%0d: got %h want 00000200", i, dreq.addr); end
            end
            if (stall === 1'b1) nstall++;
            total++; if (rvalid !== (i == 6)) begin bad++; $display("FAIL slow_rvalid c%0d: got %b want %b", i, rvalid, (i == 6)); end
            if (rvalid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++; if (rdata !== e) begin bad++; $display("FAIL slow_rdata: got %h want %h", rdata, e); end
            end
        end
        quiet();
        total++; if (nvalid != 4) begin bad++; $display("FAIL slow_valid_cycles: got %0d want 4", nvalid); end
        total++; if (nstall != 6) begin bad++; $display("FAIL slow_stall_cycles: got %0d want 6", nstall); end
    endtask

    task automatic test_abort_data();
        for (int i = 0; i < 5; i++) begin
            step();
            quiet();
            if (i == 0) begin
                in_valid      = 1'b1;
                in_req        = mk(32'h300, 4'h0, 32'h0);
                dresp.addr_ok = 1'b1;
            end
            abort         = (i == 1);
            dresp.data_ok = (i == 3);
            dresp.data    = (i == 3) ? 32'hFFFF0000 : 32'h0;
            @(negedge clk);
            total++; if (stall !== (i <= 3)) begin bad++; $display("FAIL abort_data_stall c%0d: got %b want %b", i, stall, (i <= 3)); end
            total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL abort_data_rvalid c%0d: got %b want 0", i, rvalid); end
            total++; if (dreq.valid !== (i == 0)) begin bad++; $display("FAIL abort_data_dvalid c%0d: got %b want %b", i, dreq.valid, (i == 0)); end
        end
        quiet();
    endtask

    task automatic test_abort_addr();
        for (int i = 0; i < 7; i++) begin
            step();
            quiet();
            if (i == 0) begin
                in_valid = 1'b1;
                in_req   = mk(32'h380, 4'h0, 32'h0);
            end
            abort         = (i == 1);
            dresp.addr_ok = (i == 3);
            dresp.data_ok = (i == 5);
            @(negedge clk);
            total++; if (dreq.valid !== (i <= 3)) begin bad++; $display("FAIL abort_addr_dvalid c%0d: got %b want %b", i, dreq.valid, (i <= 3)); end
            total++; if (stall !== (i <= 5)) begin bad++; $display("FAIL abort_addr_stall c%0d: got %b want %b", i, stall, (i <= 5)); end
            total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL abort_addr_rvalid c%0d: got %b want 0", i, rvalid); end
        end
        quiet();
    endtask

    task automatic test_store();
        word_t e;
        step();
        in_valid = 1'b1;
        in_req   = mk(32'h400, 4'b1111, 32'hCAFEF00D);
        dresp    = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0BADBEEF};
        exp_q.push_back(32'h0BADBEEF);
        @(negedge clk);
        total++; if (dreq.valid !== 1'b1) begin bad++; $display("FAIL store_valid: got %b want 1", dreq.valid); end
        total++; if (dreq.strobe !== 4'b1111) begin bad++; $display("FAIL store_strobe: got %b want 1111", dreq.strobe); end
        total++; if (dreq.data !== 32'hCAFEF00D) begin bad++; $display("FAIL store_data: got %h want cafef00d", dreq.data); end
        step();
        quiet();
        advance = 1'b1;
        @(negedge clk);
        total++; if (dreq.valid !== 1'b0) begin bad++; $display("FAIL store_single_cycle: got %b want 0", dreq.valid); end
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL store_done_rvalid: got %b want 1", rvalid); end
        if (rvalid) begin
            e = exp_q.pop_front();
            total++; if (rdata !== e) begin bad++; $display("FAIL store_rdata: got %h want %h", rdata, e); end
        end
        step();
        advance = 1'b0;
        @(negedge clk);
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL store_idle_rvalid: got %b want 0", rvalid); end
    endtask

    task automatic test_back_to_back();
        word_t e;
        step();
        in_valid = 1'b1;
        in_req   = mk(32'h500, 4'h0, 32'h0);
        dresp    = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h11110000};
        exp_q.push_back(32'h11110000);
        @(negedge clk);
        step();
        in_req  = mk(32'h504, 4'h0, 32'h0);
        dresp   = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h22220000};
        advance = 1'b1;
        @(negedge clk);
        total++; if (dreq.valid !== 1'b0) begin bad++; $display("FAIL b2b_no_issue_in_done: got %b want 0", dreq.valid); end
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL b2b_first_rvalid: got %b want 1", rvalid); end
        if (rvalid) begin
            e = exp_q.pop_front();
            total++; if (rdata !== e) begin bad++; $display("FAIL b2b_first_rdata: got %h want %h", rdata, e); end
        end
        step();
        advance = 1'b0;
        exp_q.push_back(32'h22220000);
        @(negedge clk);
        total++; if (dreq.valid !== 1'b1) begin bad++; $display("FAIL b2b_second_issue: got %b want 1", dreq.valid); end
        total++; if (dreq.addr !== 32'h504) begin bad++; $display("FAIL b2b_second_addr: got %h want 00000504", dreq.addr); end
        step();
        quiet();
        advance = 1'b1;
        @(negedge clk);
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL b2b_second_rvalid: got %b want 1", rvalid); end
        if (rvalid) begin
            e = exp_q.pop_front();
            total++; if (rdata !== e) begin bad++; $display("FAIL b2b_second_rdata: got %h want %h", rdata, e); end
        end
        step();
        advance = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        in_valid = 1'b1;
        in_req   = mk(32'h600, 4'h0, 32'h0);
        @(negedge clk);
        step();
        @(negedge clk);
        total++; if (dreq.valid !== 1'b1) begin bad++; $display("FAIL rstmid_addr_valid: got %b want 1", dreq.valid); end
        step();
        #1;
        resetn        = 1'b0;
        dresp.addr_ok = 1'b1;
        #1;
        total++; if (dreq.valid !== 1'b0) begin bad++; $display("FAIL rstmid_dreq_valid: got %b want 0", dreq.valid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b want 0", stall); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_rvalid: got %b want 0", rvalid); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata: got %h want 0", rdata); end
        step();
        quiet();
        resetn = 1'b1;
        step();
        dresp.data_ok = 1'b1;
        step();
        quiet();
        @(negedge clk);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_after_stall: got %b want 0", stall); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_after_rvalid: got %b want 0", rvalid); end
    endtask

`ifdef MEM_REQ_TIMEOUT_EN
    task automatic test_timeout();
        for (int i = 0; i < 11; i++) begin
            step();
            quiet();
            if (i == 0) begin
                in_valid = 1'b1;
                in_req   = mk(32'h700, 4'h0, 32'h0);
            end
            @(negedge clk);
            total++; if (timeout !== (i == 8)) begin bad++; $display("FAIL timeout_pulse c%0d: got %b want %b", i, timeout, (i == 8)); end
            total++; if (stall !== (i <= 8)) begin bad++; $display("FAIL timeout_stall c%0d: got %b want %b", i, stall, (i <= 8)); end
        end
        quiet();
    endtask
`endif

    initial begin
        test_reset();
        test_fast_load();
        test_slow_load();
        test_abort_data();
        test_abort_addr();
        test_store();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_REQ_TIMEOUT_EN
        test_timeout();
`endif
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_time_limit: got timeout want finish");
        $fatal(1);
    end

endmodule
